uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receive half of the board UART. It samples the `SIn` pin, recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) and presents each byte on a one-entry ready/valid output. That output is the byte source read by the memory-mapped IO interface at the UART receive-data address. The IO interface's `DataOutValid` status bit and its read-strobe `DataOutReady` connect directly to this block.

## Interface
- `ClockFreq`, default 50_000_000: clock frequency in Hz.
- `BaudRate`, default 115_200: line rate in baud.
- Derived values:
  - `SymbolEdgeTime = ClockFreq / BaudRate`, truncated.
  - `SampleTime = SymbolEdgeTime / 2`, truncated.
  - Counter width is `$clog2(SymbolEdgeTime)`.
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high.
- `SIn` in 1: serial line, idle high, asynchronous to `Clock`.
- `DataOut` out 8: received byte; stable while `DataOutValid` is 1.
- `DataOutValid` out 1: byte available.
- `DataOutReady` in 1: consumer accepts the byte; handshake completes on a cycle with `Valid & Ready`.
- `Overrun` out 1: one-cycle pulse when a completed byte is dropped.

## Operation
- `SIn` passes through a 2-flop synchronizer (`sin_s1` → `sin_s2`). Both flops reset to 1. All frame logic uses `sin_s2`.
- FSM states are IDLE, START, DATA and STOP.
  - **IDLE:** when `sin_s2 == 0`, go to START and clear the cycle counter.
  - **START:** the counter increments each cycle. When it reaches `SampleTime-1`, sample `sin_s2`.
    - Sample is 1 (glitch): return to IDLE, no output.
    - Sample is 0: go to DATA, clear the counter and the bit index.
  - **DATA:** when the counter reaches `SymbolEdgeTime-1`, shift `sin_s2` into bit 7 of the shift register (right shift, so the first bit received ends at bit 0) and clear the counter.
    - After the 8th bit, go to STOP with the counter cleared.
  - **STOP:** when the counter reaches `SymbolEdgeTime-1`, sample the stop bit, complete the frame (see Configuration) and go to IDLE.
- Frame completion (accepted frames only):
  - If `DataOutValid == 0`, or the handshake fires in the same cycle: load `DataOut` with the shift register and set `DataOutValid = 1`.
  - Otherwise: discard the new byte, keep `DataOut` unchanged, pulse `Overrun` for 1 cycle.
- A handshake with no completion in that cycle clears `DataOutValid` on the next edge. `DataOut` holds its last value.
- Reception of the next frame proceeds while a byte is pending, so one byte of buffering is provided.
- Reset values:
  - `DataOut` = 8'h00, `DataOutValid` = 0, `Overrun` = 0.
  - FSM = IDLE; counters = 0; shift register = 0.
- Reset mid-frame aborts the frame. After release, the block waits in IDLE for a new falling edge.

## Timing
- Let t0 be the edge at which `sin_s1` first captures the start bit's 0.
  - IDLE sees `sin_s2 == 0` at edge t0+1 and enters START at edge t0+2.
  - Start sample is taken at edge t0+1+`SampleTime`.
  - Data bit k (k=0..7) is sampled at edge t0+1+`SampleTime`+(k+1)·`SymbolEdgeTime`.
  - Stop is sampled at edge t0+1+`SampleTime`+9·`SymbolEdgeTime`.
  - `DataOutValid` is 1 after that same edge.
- Output is registered; there is no combinational path from `DataOutReady` to any output.
- Back-to-back frames: the next start bit is accepted from the first IDLE cycle after STOP. Zero-length idle between frames is supported.
- Line held low (break): repeated frames of 0x00 with stop bit 0 are handled per Configuration.

## Configuration
- `UART_RX_FRAME_CHECK_EN` defined:
  - A stop sample of 0 is a framing error. The byte is discarded, `DataOutValid` and `Overrun` are unaffected, and the FSM returns to IDLE.
- `UART_RX_FRAME_CHECK_EN` undefined:
  - The stop-bit value is ignored and every frame completes normally.

## Test plan
All scenarios use `ClockFreq=1000` and `BaudRate=100`, giving `SymbolEdgeTime=10` and `SampleTime=5`.
1. **Reset values.** Assert `Reset` asynchronously mid-cycle → outputs go to 0 immediately (`DataOut` 0x00, `DataOutValid` 0, `Overrun` 0). Release, hold `SIn`=1 for 200 cycles → `DataOutValid` stays 0.
2. **Single byte and latency.** Send 0xA5 with a 10-cycle bit period → `DataOutValid` rises at edge t0+96 with `DataOut`=0xA5. Pulse `DataOutReady` → `DataOutValid`=0 on the next edge.
3. **Glitch and reset mid-frame.**
   - 3-cycle low pulse on `SIn` → no output, FSM back in IDLE.
   - Assert `Reset` during bit 4 of 0x3C, then send 0x81 → only 0x81 is delivered.
4. **Overrun and simultaneous events.** Send 0x11 then 0x22 back-to-back with `DataOutReady`=0 → `DataOut` stays 0x11 and `Overrun` pulses once. Repeat with `DataOutReady`=1 exactly on the completion edge of 0x22 → `DataOut`=0x22, `DataOutValid` stays 1, no `Overrun` pulse.
5. **Stop bit 0.** Send 0x5A with stop bit 0:
   - With `UART_RX_FRAME_CHECK_EN` → no byte delivered.
   - Without it → `DataOut`=0x5A.
   - In both builds, a following 0x5A with a valid stop bit is delivered.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: receive half of the board UART.
// Recovers 8N1 frames (start, 8 data bits LSB first, stop) from the
// asynchronous SIn pin and presents each byte on a one-entry ready/valid
// output, giving one byte of buffering while the next frame arrives.
//
// Optional feature macro: UART_RX_FRAME_CHECK_EN
//   defined   - a stop sample of 0 is a framing error and the byte is dropped
//   undefined - the stop-bit value is ignored, every frame completes
//
// Output handshake: DataOut/DataOutValid are registered. A transfer happens
// on every rising edge where DataOutValid and DataOutReady are both 1. Once
// DataOutValid rises it stays high and DataOut stays stable until that
// transfer. Valid never depends combinationally on Ready.
//
// fsm_state is a debug view of the receive FSM
// (0 IDLE, 1 START, 2 DATA, 3 STOP).

module uart_receiver #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SIn,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    output logic       Overrun,
    output logic [1:0] fsm_state
);

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int SampleTime     = SymbolEdgeTime / 2;
    localparam int CntWidth       = $clog2(SymbolEdgeTime);

    // The start check fires on the edge where the counter would step to
    // SampleTime-1. Counting from the IDLE->START edge, that lands the
    // start sample SampleTime edges after sin_s2 first shows the 0, and
    // every later sample a whole symbol further on, i.e. mid-bit.
    // Requires SampleTime >= 2 (at least 4 clocks per bit).
    localparam logic [CntWidth-1:0] START_LAST = CntWidth'(SampleTime - 2);
    localparam logic [CntWidth-1:0] BIT_LAST   = CntWidth'(SymbolEdgeTime - 1);
    localparam logic [CntWidth-1:0] CNT_ONE    = CntWidth'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    logic                sin_s1;
    logic                sin_s2;
    logic [CntWidth-1:0] cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic                handshake;
    logic                stop_ok;

    assign handshake = DataOutValid & DataOutReady;
    assign fsm_state = state;

`ifdef UART_RX_FRAME_CHECK_EN
    // A low stop bit means the frame was not properly terminated.
    assign stop_ok = sin_s2;
`else
    // The stop-bit value is not inspected; every frame is accepted.
    assign stop_ok = 1'b1;
`endif

    // Two-flop synchronizer for the asynchronous serial line (idle high).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sin_s1 <= 1'b1;
            sin_s2 <= 1'b1;
        end else begin
            sin_s1 <= SIn;
            sin_s2 <= sin_s1;
        end
    end

    // Frame FSM with bit timing, shift register and registered output slot.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            DataOut      <= 8'h00;
            DataOutValid <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            Overrun <= 1'b0;

            // A consumed byte frees the slot; a frame completing in the
            // same cycle overrides this below and refills it.
            if (handshake) begin
                DataOutValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!sin_s2) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == START_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A line already back high mid start-bit is a glitch.
                        if (sin_s2) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        // LSB arrives first, so shift right from the top.
                        shift <= {sin_s2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (stop_ok) begin
                            if (!DataOutValid || handshake) begin
                                DataOut      <= shift;
                                DataOutValid <= 1'b1;
                            end else begin
                                // Slot still occupied: drop the new byte.
                                Overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver at 10 clocks per bit (ClockFreq=1000,
// BaudRate=100). Inputs change 2 time units after a rising edge and
// outputs are read there or on the falling edge.

module tb_uart_receiver;

    localparam int CLK_HZ  = 1000;
    localparam int BAUD    = 100;
    localparam int BIT_CYC = 10;

`ifdef UART_RX_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       s_in  = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       overrun;
    logic [1:0] fsm_state;

    int         checks      = 0;
    int         passes      = 0;
    int         overrun_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] tbl_data[8];
    logic       tbl_stop[8];

    // Clock and DUT
    always #5 clock = ~clock;

    uart_receiver #(
        .ClockFreq(CLK_HZ),
        .BaudRate (BAUD)
    ) dut (
        .Clock       (clock),
        .Reset       (reset),
        .SIn         (s_in),
        .DataOut     (data_out),
        .DataOutValid(valid),
        .DataOutReady(ready),
        .Overrun     (overrun),
        .fsm_state   (fsm_state)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance n rising edges, landing 2 units after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // Drive one 8N1 frame. A low stop bit is held for only half a bit so
    // the line is high again before the FSM returns to IDLE.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        s_in = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            s_in = d[i];
            tick(BIT_CYC);
        end
        s_in = stop;
        tick(stop ? BIT_CYC : BIT_CYC / 2);
        s_in = 1'b1;
    endtask

    // One-cycle ready pulse; valid must drop on the following edge.
    task automatic accept_byte(input string name);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check(name, {31'd0, valid}, 32'd1 - 32'd1);
    endtask

    // Scoreboard: every completed handshake pops one expected byte.
    always @(negedge clock) begin
        if (overrun) begin
            overrun_cnt++;
        end
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: got byte 0x%0h, expected no byte", data_out);
            end else begin
                check("sb_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] last;
        int         base;

        // Vector table: {data, stop bit} -> expected slot contents.
        tbl_data = '{8'h00, 8'hFF, 8'h3C, 8'h01, 8'h80, 8'h5A, 8'h5A, 8'h00};
        tbl_stop = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl_data[7] = 8'($urandom_range(0, 255));
        last = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            vecs[i].data      = tbl_data[i];
            vecs[i].stop      = tbl_stop[i];
            vecs[i].exp_valid = tbl_stop[i] | ~FRAME_CHECK;
            if (vecs[i].exp_valid) begin
                last = tbl_data[i];
            end
            vecs[i].exp_data = last;
        end

        // Power-up reset
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        check("rst_data", {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        tick(5);

        // Single byte latency: valid rises on edge t0+96
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(96);
                check("lat_valid_early", {31'd0, valid}, 32'd0);
                tick(1);
                check("lat_valid", {31'd0, valid}, 32'd1);
                check("lat_data", {24'd0, data_out}, 32'hA5);
            end
        join
        tick(2);
        accept_byte("lat_clear");

        // Table-driven frames, including a low stop bit
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_valid) begin
                exp_q.push_back(vecs[i].data);
            end
            send_frame(vecs[i].data, vecs[i].stop);
            tick(3);
            check($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_data", i), {24'd0, data_out}, {24'd0, vecs[i].exp_data});
            if (valid) begin
                accept_byte($sformatf("vec%0d_clear", i));
            end
            tick(2);
        end

        // Glitch: 3-cycle low pulse enters START then falls back to IDLE
        s_in = 1'b0;
        tick(3);
        check("glitch_start", {30'd0, fsm_state}, 32'd1);
        s_in = 1'b1;
        tick(12);
        check("glitch_idle", {30'd0, fsm_state}, 32'd0);
        check("glitch_valid", {31'd0, valid}, 32'd0);

        // Reset during bit 4 of 0x3C, held to the end of that frame
        fork
            send_frame(8'h3C, 1'b1);
            begin
                tick(55);
                reset = 1'b1;
                #1;
                check("midrst_state", {30'd0, fsm_state}, 32'd0);
                check("midrst_data", {24'd0, data_out}, 32'h00);
                tick(45);
                reset = 1'b0;
            end
        join
        tick(5);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        tick(3);
        check("after_rst_valid", {31'd0, valid}, 32'd1);
        check("after_rst_data", {24'd0, data_out}, 32'h81);
        accept_byte("after_rst_clear");
        tick(3);

        // Overrun: back-to-back 0x11, 0x22 with no reader
        base = overrun_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(3);
        check("ovr_data", {24'd0, data_out}, 32'h11);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        check("ovr_pulses", overrun_cnt - base, 32'd1);
        accept_byte("ovr_clear");
        tick(3);

        // Reader accepts 0x11 exactly on the completion edge of 0x22
        base = overrun_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                tick(196);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
                check("simul_data", {24'd0, data_out}, 32'h22);
                check("simul_valid", {31'd0, valid}, 32'd1);
            end
        join
        tick(3);
        check("simul_no_ovr", overrun_cnt - base, 32'd0);
        accept_byte("simul_clear");
        tick(3);

        // Asynchronous reset mid-cycle with a byte pending
        send_frame(8'hC3, 1'b1);
        tick(3);
        check("pre_rst_data", {24'd0, data_out}, 32'hC3);
        reset = 1'b1;
        #1;
        check("async_rst_data", {24'd0, data_out}, 32'h00);
        check("async_rst_valid", {31'd0, valid}, 32'd0);
        check("async_rst_overrun", {31'd0, overrun}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(200);
        check("idle_valid", {31'd0, valid}, 32'd0);
        check("idle_state", {30'd0, fsm_state}, 32'd0);

        check("sb_drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
